// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: dmem handshake, store forwarding, MEM/WB register
module mem_stage_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en_in,
   input  logic        mem_wr_in,
   input  logic        rf_wr_in,
   input  logic        halt_in,
   input  logic [3:0]  wreg_in,
   input  logic [3:0]  opcode_in,
   input  logic [1:0]  wb_select_in,
   input  logic [15:0] alu_in,
   input  logic [15:0] pc_in,
   input  logic [15:0] regread1_in,
   input  logic [3:0]  srcreg1_in,
   input  logic        wb_rf_wr,
   input  logic [3:0]  wb_wreg,
   input  logic [15:0] wb_data,
   output logic        dmem_req,
   output logic        dmem_wr,
   output logic [15:0] dmem_addr,
   output logic [15:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [15:0] dmem_rdata,
   output logic        stall,
   output logic        halt_out,
   output logic        rf_wr_out,
   output logic [3:0]  wreg_out,
   output logic [3:0]  opcode_out,
   output logic [1:0]  wb_select_out,
   output logic [15:0] alu_out,
   output logic [15:0] mem_data_out,
   output logic [15:0] pc_out,
   output logic [15:0] stall_cycles
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_wr;

   logic        w_fwd;
   logic [15:0] w_store;
   logic        w_load;
   logic        w_latch;
   logic [15:0] w_mdata;

   // Register 0 is hardwired zero, so a WB write to it never forwards.
   assign w_fwd   = wb_rf_wr && (wb_wreg == srcreg1_in) && (wb_wreg != 4'd0);
   assign w_store = w_fwd ? wb_data : regread1_in;

   always_comb begin
      w_next     = r_state;
      dmem_req   = 1'b0;
      dmem_wr    = 1'b0;
      dmem_addr  = 16'd0;
      dmem_wdata = 16'd0;
      stall      = 1'b0;
      w_load     = 1'b0;
      w_latch    = 1'b0;
      w_mdata    = 16'd0;
      if (rst) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem_en_in) begin
                  dmem_req   = 1'b1;
                  dmem_wr    = mem_wr_in;
                  dmem_addr  = alu_in;
                  dmem_wdata = w_store;
                  if (dmem_ready) begin
                     w_load  = 1'b1;
                     w_mdata = mem_wr_in ? 16'd0 : dmem_rdata;
                  end else begin
                     stall   = 1'b1;
                     w_latch = 1'b1;
                     w_next  = S_BUSY;
                  end
               end else begin
                  w_load = 1'b1;
               end
            end
            S_BUSY: begin
               // Replay the captured request; WB may have moved on, so no re-forwarding.
               dmem_req   = 1'b1;
               dmem_wr    = r_wr;
               dmem_addr  = r_addr;
               dmem_wdata = r_wdata;
               stall      = !dmem_ready;
               if (dmem_ready) begin
                  w_load  = 1'b1;
                  w_mdata = r_wr ? 16'd0 : dmem_rdata;
                  w_next  = S_IDLE;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_addr        <= 16'd0;
         r_wdata       <= 16'd0;
         r_wr          <= 1'b0;
         halt_out      <= 1'b0;
         rf_wr_out     <= 1'b0;
         wreg_out      <= 4'd0;
         opcode_out    <= 4'd0;
         wb_select_out <= 2'd0;
         alu_out       <= 16'd0;
         mem_data_out  <= 16'd0;
         pc_out        <= 16'd0;
         stall_cycles  <= 16'd0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_addr  <= alu_in;
            r_wdata <= w_store;
            r_wr    <= mem_wr_in;
         end
         if (w_load) begin
            halt_out      <= halt_in;
            rf_wr_out     <= rf_wr_in;
            wreg_out      <= wreg_in;
            opcode_out    <= opcode_in;
            wb_select_out <= wb_select_in;
            alu_out       <= alu_in;
            mem_data_out  <= w_mdata;
            pc_out        <= pc_in;
         end else begin
            halt_out      <= 1'b0;
            rf_wr_out     <= 1'b0;
            wreg_out      <= 4'd0;
            opcode_out    <= 4'd0;
            wb_select_out <= 2'd0;
            alu_out       <= 16'd0;
            mem_data_out  <= 16'd0;
            pc_out        <= 16'd0;
         end
         if (stall && (stall_cycles != 16'hFFFF))
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller for the 16-bit pipelined core. It consumes the EX/MEM pipeline register outputs and drives the data-memory request/ready handshake. It forwards store data from the write-back stage and produces the registered MEM/WB payload. When the memory is not ready, it stalls the pipeline and inserts bubbles downstream.

## Interface
Parameters:
- none; all widths fixed (16-bit data/address, 4-bit register IDs, 4-bit opcode, 2-bit WB select).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- mem_en_in  in  1  EX/MEM: instruction accesses data memory
- mem_wr_in  in  1  EX/MEM: access is a store (valid only with mem_en_in)
- rf_wr_in  in  1  EX/MEM: instruction writes register file
- halt_in  in  1  EX/MEM: halt instruction
- wreg_in  in  4  EX/MEM: destination register
- opcode_in  in  4  EX/MEM: opcode
- wb_select_in  in  2  EX/MEM: 0 = ALU, 1 = memory, other = PC
- alu_in  in  16  EX/MEM: ALU result / memory address
- pc_in  in  16  EX/MEM: PC+2 of instruction
- regread1_in  in  16  EX/MEM: store data as read in ID
- srcreg1_in  in  4  EX/MEM: source register of store data
- wb_rf_wr  in  1  WB stage register-write enable
- wb_wreg  in  4  WB stage destination register
- wb_data  in  16  WB stage write-back value
- dmem_req  out  1  memory request
- dmem_wr  out  1  request is write
- dmem_addr  out  16  request address
- dmem_wdata  out  16  write data
- dmem_ready  in  1  memory completes request this cycle; dmem_rdata valid
- dmem_rdata  in  16  read data
- stall  out  1  hold PC/IF-ID/ID-EX/EX-MEM (drives their WriteEnable low)
- halt_out, rf_wr_out  out  1  MEM/WB control
- wreg_out, opcode_out  out  4  MEM/WB
- wb_select_out  out  2  MEM/WB
- alu_out, mem_data_out, pc_out  out  16  MEM/WB data
- stall_cycles  out  16  saturating count of stall cycles since reset

## Operation
- FSM states: IDLE, BUSY. Reset state IDLE.
- Store data forwarding applies in IDLE only:
  - fwd = wb_rf_wr && wb_wreg == srcreg1_in && wb_wreg != 0.
  - Store data = fwd ? wb_data : regread1_in.
- IDLE, mem_en_in = 0:
  - dmem_req = 0.
  - MEM/WB loads the inputs; mem_data_out = 0; stall = 0.
- IDLE, mem_en_in = 1:
  - dmem_req = 1, dmem_addr = alu_in, dmem_wr = mem_wr_in, dmem_wdata = store data, all combinational.
  - If dmem_ready: MEM/WB loads the instruction, with mem_data_out = mem_wr_in ? 0 : dmem_rdata. Stay IDLE; stall = 0.
  - Else: latch addr/wr/wdata into the request holding register; go to BUSY; stall = 1; MEM/WB loads a bubble.
- BUSY:
  - dmem_req = 1, driven from the latched addr/wr/wdata; forwarding is not re-evaluated.
  - stall = !dmem_ready. EX/MEM inputs remain stable because they are held by stall.
  - dmem_ready = 1: MEM/WB loads the instruction as above; go to IDLE.
  - Otherwise stay in BUSY; MEM/WB loads a bubble.
- Bubble: rf_wr_out = 0, halt_out = 0, all other MEM/WB fields 0.
- When dmem_req = 0, dmem_wr/addr/wdata are 0.
- dmem_ready is ignored when dmem_req = 0.
- stall_cycles increments on every cycle with stall = 1. It saturates at 0xFFFF.
- halt_in with mem_en_in = 0 passes through like any non-memory instruction.

## Timing
- All MEM/WB outputs and stall_cycles are registered. Reset value of each is 0.
- dmem_req/wr/addr/wdata and stall are combinational from state and inputs. All are forced to 0 while rst = 1.
- Non-memory instruction latency: 1 cycle, EX/MEM to MEM/WB outputs.
- Memory instruction latency: 1 + N cycles, where N is the number of cycles dmem_ready stays low after the request is first asserted. stall is high for exactly N cycles.
- Once asserted, the request is held stable until dmem_ready. At most one request is outstanding.
- rst in BUSY: the next state is IDLE, the request is abandoned, and all outputs return to 0 after that edge. dmem_req is 0 during the reset cycle.
- Simultaneous dmem_ready and entry into IDLE: an instruction entering IDLE from EX/MEM on the cycle after completion is processed normally. There are no dead cycles between back-to-back memory accesses.

## Test plan
- Reset: assert rst 2 cycles with random inputs -> every MEM/WB output, stall, stall_cycles and dmem_req = 0.
- ALU op: rf_wr_in = 1, wreg_in = 3, alu_in = 0x1234, wb_select_in = 0 -> next cycle rf_wr_out = 1, wreg_out = 3, alu_out = 0x1234, stall never high.
- Load, zero-wait: alu_in = 0x0040, dmem_ready = 1 in the same cycle, dmem_rdata = 0xBEEF -> dmem_addr = 0x0040, next cycle mem_data_out = 0xBEEF, stall_cycles = 0.
- Load, 3-wait: dmem_ready low 3 cycles then high with 0x00C3 -> stall high 3 cycles, 3 bubble cycles on MEM/WB, then mem_data_out = 0x00C3; stall_cycles = 3.
- Store forwarding:
  - Case 1: srcreg1_in = 5, regread1_in = 0x1111, wb_rf_wr = 1, wb_wreg = 5, wb_data = 0xA5A5, 2 wait cycles with wb_data changed to 0 -> dmem_wdata = 0xA5A5 throughout; dmem_wr = 1.
  - Case 2: repeat with srcreg1_in = wb_wreg = 0 -> dmem_wdata = 0x1111.
- Reset mid-access: load in BUSY, assert rst for 1 cycle -> dmem_req = 0 in that cycle; after the edge state is IDLE and stall = 0; a following zero-wait load completes normally.
